// File: rtl/anim_frame_sequencer_if.sv
// rtl/anim_frame_sequencer_if.sv - control, table-write and frame-output bundle of the frame sequencer
interface anim_frame_sequencer_if #(
    parameter int ANI_W   = 6,
    parameter int FRAME_W = 6,
    parameter int PRESC_W = 24
);
    logic               en;
    logic [PRESC_W-1:0] div;
    logic [ANI_W-1:0]   ani_sel;
    logic [1:0]         mode;
    logic               restart;
    logic               wr_en;
    logic [ANI_W-1:0]   wr_addr;
    logic [FRAME_W-1:0] wr_data;
    logic [FRAME_W-1:0] frame;
    logic               frame_stb;
    logic               wrap;
    logic               done;
    logic [FRAME_W-1:0] cur_limit;

    modport master (
        output en, div, ani_sel, mode, restart, wr_en, wr_addr, wr_data,
        input  frame, frame_stb, wrap, done, cur_limit
    );

    modport slave (
        input  en, div, ani_sel, mode, restart, wr_en, wr_addr, wr_data,
        output frame, frame_stb, wrap, done, cur_limit
    );
endinterface

// File: rtl/anim_frame_sequencer.sv
// rtl/anim_frame_sequencer.sv - per-animation frame-limit table with prescaled loop/ping-pong/one-shot frame counter
module anim_frame_sequencer #(
    parameter int ANI_W     = 6,
    parameter int FRAME_W   = 6,
    parameter int PRESC_W   = 24,
    parameter int DEF_LIMIT = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    anim_frame_sequencer_if.slave  bus
);
    localparam int NUM_ANI = 2**ANI_W;

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    dir_t               dir_q, dir_d;
    logic [FRAME_W-1:0] tbl [NUM_ANI];
    logic [FRAME_W-1:0] entry, lim, last;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [PRESC_W-1:0] cnt_q, cnt_d;
    logic [ANI_W-1:0]   ani_q;
    logic [1:0]         mode_q;
    logic               done_q, done_d;
    logic               stb_q, stb_d;
    logic               wrap_q, wrap_d;
    logic               restart_any;
    logic               tick;

    // A zero entry is kept as written but behaves as a one-frame animation
    assign entry       = tbl[bus.ani_sel];
    assign lim         = (entry == '0) ? FRAME_W'(1) : entry;
    assign last        = lim - FRAME_W'(1);
    assign restart_any = bus.restart | (bus.ani_sel != ani_q) | (bus.mode != mode_q);
    assign tick        = bus.en & (cnt_q == bus.div);

    always_comb begin
        cnt_d = cnt_q;
        if (restart_any)
            cnt_d = '0;
        else if (bus.en)
            cnt_d = (cnt_q >= bus.div) ? '0 : cnt_q + PRESC_W'(1);
    end

    always_comb begin
        frame_d = frame_q;
        dir_d   = dir_q;
        done_d  = done_q;
        stb_d   = 1'b0;
        wrap_d  = 1'b0;
        if (restart_any) begin
            frame_d = '0;
            dir_d   = DIR_UP;
            done_d  = 1'b0;
        end else if (tick && (bus.mode != 2'b11) && !done_q) begin
            stb_d = 1'b1;
            if (frame_q >= lim) begin
                frame_d = '0;
                dir_d   = DIR_UP;
                wrap_d  = 1'b1;
            end else begin
                case (bus.mode)
                    2'b00: begin
                        if (frame_q == last) begin
                            frame_d = '0;
                            wrap_d  = 1'b1;
                        end else begin
                            frame_d = frame_q + FRAME_W'(1);
                        end
                    end
                    2'b01: begin
                        // Reaching 0 from above is the wrap; L=1 and L=2 reach it from the top end directly
                        if (dir_q == DIR_UP && frame_q != last) begin
                            frame_d = frame_q + FRAME_W'(1);
                        end else if (frame_q <= FRAME_W'(1)) begin
                            frame_d = '0;
                            dir_d   = DIR_UP;
                            wrap_d  = 1'b1;
                        end else begin
                            frame_d = frame_q - FRAME_W'(1);
                            dir_d   = DIR_DOWN;
                        end
                    end
                    2'b10: begin
                        if (frame_q == last) begin
                            done_d = 1'b1;
                        end else begin
                            frame_d = frame_q + FRAME_W'(1);
                            if (frame_q + FRAME_W'(1) == last)
                                done_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ANI; i++)
                tbl[i] <= FRAME_W'(DEF_LIMIT);
            frame_q <= '0;
            dir_q   <= DIR_UP;
            done_q  <= 1'b0;
            stb_q   <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
            ani_q   <= '0;
            mode_q  <= 2'b00;
        end else begin
            if (bus.wr_en)
                tbl[bus.wr_addr] <= bus.wr_data;
            frame_q <= frame_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            stb_q   <= stb_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
            ani_q   <= bus.ani_sel;
            mode_q  <= bus.mode;
        end
    end

    assign bus.frame     = frame_q;
    assign bus.frame_stb = stb_q;
    assign bus.wrap      = wrap_q;
    assign bus.done      = done_q;
    assign bus.cur_limit = lim;
endmodule
